// File: rtl/dop_dsd_decoder_pkg.sv
// Shared constants and enums for the DoP decoder.
package dop_pkg;

  localparam logic [7:0] DOP_MK_A = 8'h05;
  localparam logic [7:0] DOP_MK_B = 8'hFA;
  localparam logic [7:0] DSD_IDLE = 8'h69;

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} lock_st_e;
  typedef enum logic [1:0] {MK_NONE, MK_A, MK_B} prev_mk_e;

  // Classify a marker byte; anything other than the two DoP markers is MK_NONE.
  function automatic prev_mk_e mk_class(input logic [7:0] mk);
    if (mk == DOP_MK_A)      return MK_A;
    else if (mk == DOP_MK_B) return MK_B;
    else                     return MK_NONE;
  endfunction

endpackage

// File: rtl/dop_dsd_decoder_lock_fsm.sv
// DoP marker check and lock/miss hysteresis.
// accept_o: good frame while already LOCKED; unlock_o: this frame drops to UNLOCKED.
module dop_lock_fsm
  import dop_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DW     = 16,
  parameter int LOCK_N = 4,
  parameter int MISS_N = 2
) (
  input  logic                  bclk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [NCH*(DW+8)-1:0] data_i,
  output logic                  good_o,
  output logic                  locked_o,
  output logic                  accept_o,
  output logic                  unlock_o,
  output logic                  bad_o
);
  localparam int SW = DW + 8;
  localparam int LW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(MISS_N + 1);

  lock_st_e       st;
  prev_mk_e       prev, cur;
  logic [LW-1:0]  lcnt, lcnt_inc;
  logic [MW-1:0]  mcnt, mcnt_inc;
  logic           same;
  logic [7:0]     mk0;

  // All channel markers must match; the common marker must be valid and alternate.
  always_comb begin
    mk0  = data_i[DW +: 8];
    same = 1'b1;
    for (int c = 1; c < NCH; c++)
      if (data_i[c*SW + DW +: 8] != mk0) same = 1'b0;
    cur    = mk_class(mk0);
    good_o = same && (cur != MK_NONE) && (cur != prev);
  end

  assign lcnt_inc = lcnt + LW'(1);
  assign mcnt_inc = mcnt + MW'(1);
  assign bad_o    = valid_i && !good_o;
  assign accept_o = valid_i && good_o && (st == LOCKED);
  assign unlock_o = bad_o && ((st == LOCKING) ||
                              ((st == LOCKED) && (mcnt_inc == MW'(MISS_N))));
  assign locked_o = (st == LOCKED);

  // Lock state machine, advanced once per frame strobe.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      st   <= UNLOCKED;
      prev <= MK_NONE;
      lcnt <= '0;
      mcnt <= '0;
    end else if (valid_i) begin
      if (unlock_o) begin
        st   <= UNLOCKED;
        prev <= MK_NONE;
        lcnt <= '0;
        mcnt <= '0;
      end else if (good_o) begin
        prev <= cur;
        mcnt <= '0;
        case (st)
          UNLOCKED: begin
            lcnt <= LW'(1);
            st   <= (LOCK_N == 1) ? LOCKED : LOCKING;
          end
          LOCKING: begin
            lcnt <= lcnt_inc;
            if (lcnt_inc == LW'(LOCK_N)) st <= LOCKED;
          end
          LOCKED:  ;
          default: st <= UNLOCKED;
        endcase
      end else if (st == LOCKED) begin
        mcnt <= mcnt_inc;
      end
    end
  end

endmodule

// File: rtl/dop_dsd_decoder.sv
// Multi-channel DoP decoder and DSD serialiser.
// Optional DOP_ERR_CNT_EN: builds a saturating 16-bit bad-frame counter on err_cnt_o.
module dop_dsd_decoder
  import dop_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DW     = 16,
  parameter int DIV    = 4,
  parameter int LOCK_N = 4,
  parameter int MISS_N = 2
) (
  input  logic                  bclk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [NCH*(DW+8)-1:0] data_i,
  output logic [NCH-1:0]        dsd_o,
  output logic                  dsd_clk_o,
  output logic                  locked_o,
  output logic                  underrun_o,
  output logic                  overflow_o,
  output logic [15:0]           err_cnt_o
);
  localparam int SW = DW + 8;
  localparam int CW = $clog2(DIV);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  // Idle byte repeated from the MSB down, cut to DW bits.
  function automatic logic [DW-1:0] idle_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[DW-1-i] = DSD_IDLE[7 - (i % 8)];
    return w;
  endfunction
  localparam logic [DW-1:0] IDLE_W = idle_word();

  logic good, accept, unlock, bad;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bcnt;
  logic tick, load, consume;
  logic [NCH-1:0][DW-1:0] pay, pend;
  logic pend_vld;

  dop_lock_fsm #(.NCH(NCH), .DW(DW), .LOCK_N(LOCK_N), .MISS_N(MISS_N)) u_lock (
    .bclk     (bclk),
    .rst      (rst),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .good_o   (good),
    .locked_o (locked_o),
    .accept_o (accept),
    .unlock_o (unlock),
    .bad_o    (bad)
  );

  logic unused_good;
  assign unused_good = good;

  assign cnt_n   = (cnt == CW'(DIV-1)) ? '0 : cnt + CW'(1);
  assign tick    = (cnt == CW'(DIV-1));
  assign load    = tick && (bcnt == '0);
  assign consume = load && pend_vld;

  // Free-running divider; DSD clock is low for the first half of each bit.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      dsd_clk_o <= 1'b0;
      bcnt      <= '0;
    end else begin
      cnt       <= cnt_n;
      dsd_clk_o <= (cnt_n >= CW'(DIV/2));
      if (tick) bcnt <= (bcnt == BW'(DW-1)) ? '0 : bcnt + BW'(1);
    end
  end

  // Pending word: a consume on the same edge reads the old word, the new one stays pending.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      pend_vld   <= 1'b0;
      overflow_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      if (accept) pend <= pay;
      if (unlock)       pend_vld <= 1'b0;
      else if (accept)  pend_vld <= 1'b1;
      else if (consume) pend_vld <= 1'b0;
      overflow_o <= accept && pend_vld && !consume;
      underrun_o <= load && !pend_vld && locked_o;
    end
  end

  // Per-channel payload extraction and MSB-first shifter.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0] sr, cur;
    logic          q;
    assign pay[c] = data_i[c*SW +: DW];
    assign cur    = load ? (pend_vld ? pend[c] : IDLE_W) : sr;
    assign dsd_o[c] = q;
    always_ff @(posedge bclk or posedge rst) begin
      if (rst) begin
        sr <= '0;
        q  <= 1'b0;
      end else if (tick) begin
        q  <= cur[DW-1];
        sr <= cur << 1;
      end
    end
  end

`ifdef DOP_ERR_CNT_EN
  logic [15:0] err_cnt;
  // Saturating bad-frame counter, cleared only by reset.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst)                           err_cnt <= '0;
    else if (bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
  assign err_cnt_o = err_cnt;
`else
  logic unused_bad;
  assign unused_bad = bad;
  assign err_cnt_o  = '0;
`endif

endmodule
